// File: rtl/shared_mem_pkg.sv
// Shared definitions for the two-core shared-memory arbiter:
// FSM state encoding, core identifiers and the core count.
package shared_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic CORE0   = 1'b0;
    localparam logic CORE1   = 1'b1;
    localparam int   N_CORES = 2;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester grant selection.
// ARB_ROUND_ROBIN_EN defined : ties go to the core not granted most recently.
// ARB_ROUND_ROBIN_EN undefined: fixed priority, core 0 always wins a tie
//                              (the last-grant input is then ignored).
import shared_mem_pkg::*;

module rr_arbiter2 (
    input  logic [N_CORES-1:0] req_i,
    input  logic               last_i,
    output logic [N_CORES-1:0] grant_o
);

`ifdef ARB_ROUND_ROBIN_EN
    // One-hot grant; on a tie favour the core that did not win last time
    always_comb begin
        grant_o = 2'b00;
        if (req_i == 2'b11) begin
            grant_o = (last_i == CORE0) ? 2'b10 : 2'b01;
        end else begin
            grant_o = req_i;
        end
    end
`else
    logic unused_last;
    assign unused_last = last_i;

    // One-hot grant; core 0 has absolute priority
    always_comb begin
        grant_o = 2'b00;
        if (req_i[0]) begin
            grant_o = 2'b01;
        end else if (req_i[1]) begin
            grant_o = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/shared_mem_arbiter.sv
// Serialises load/store requests from two cores onto a single-port memory
// with one-cycle registered read latency. Each access walks
// IDLE -> ISSUE -> CAPTURE -> DONE; the winner's ack pulses in DONE.
// Tie-break policy is selected by the ARB_ROUND_ROBIN_EN macro.
//
// Handshake: a core raises req with stable addr/we/wdata and holds it until
// it sees ack high for one cycle; it drops req in the following cycle. A req
// still high in the IDLE cycle after ack counts as a fresh request.
import shared_mem_pkg::*;

module shared_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              we0,
    input  logic              we1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write_enable,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    output state_t            dbg_state_o
);

    state_t              state_q;
    logic                win_q;
    logic                we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                ack0_q;
    logic                ack1_q;
    logic [DATA_W-1:0]   rdata0_q;
    logic [DATA_W-1:0]   rdata1_q;

    logic [N_CORES-1:0]  grant;
    logic                last_grant;
    logic                win_d;
    logic                we_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q;
    assign last_grant = last_q;
`else
    assign last_grant = CORE1;
`endif

    rr_arbiter2 u_arb (
        .req_i   ({req1, req0}),
        .last_i  (last_grant),
        .grant_o (grant)
    );

    // Mux the winning core's request fields ready for latching in IDLE
    always_comb begin
        win_d   = grant[1] ? CORE1  : CORE0;
        we_d    = grant[1] ? we1    : we0;
        addr_d  = grant[1] ? addr1  : addr0;
        wdata_d = grant[1] ? wdata1 : wdata0;
    end

    // Access sequencer; the memory port registers are loaded at grant time so
    // they are already driving the memory during ISSUE
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            win_q       <= CORE0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q      <= CORE1;
`endif
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|grant) begin
                        win_q       <= win_d;
                        we_q        <= we_d;
                        mem_addr_q  <= addr_d;
                        mem_wdata_q <= wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
                        last_q      <= win_d;
`endif
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    // Read data reflects the pre-write contents for a store
                    if (win_q == CORE1) begin
                        rdata1_q <= mem_read_data;
                        ack1_q   <= 1'b1;
                    end else begin
                        rdata0_q <= mem_read_data;
                        ack0_q   <= 1'b1;
                    end
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Write strobe only during ISSUE, and never while reset is asserted
    assign mem_write_enable = (state_q == ISSUE) && we_q && !reset;

    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_wdata_q;
    assign ack0           = ack0_q;
    assign ack1           = ack1_q;
    assign rdata0         = rdata0_q;
    assign rdata1         = rdata1_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter with a behavioural single-port memory
// (registered read, read-before-write, word-indexed on addr[7:2]).
import shared_mem_pkg::*;

module tb_shared_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic              req0, req1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic              we0, we1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_write_enable;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;
  state_t            dbg_state;

  shared_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .req0             (req0),
    .req1             (req1),
    .addr0            (addr0),
    .addr1            (addr1),
    .we0              (we0),
    .we1              (we1),
    .wdata0           (wdata0),
    .wdata1           (wdata1),
    .ack0             (ack0),
    .ack1             (ack1),
    .rdata0           (rdata0),
    .rdata1           (rdata1),
    .mem_addr         (mem_addr),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data),
    .dbg_state_o      (dbg_state)
  );

  // ---------------- memory model ----------------
  logic              mem_init = 1'b1;
  logic [DATA_W-1:0] mem [0:63];

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) begin
        mem[i] <= (i == 0) ? 32'h11 : (i == 1) ? 32'h22 : (i == 32) ? 32'h3 : 32'h0;
      end
      mem_read_data <= '0;
    end else begin
      mem_read_data <= mem[mem_addr[7:2]];
      if (mem_write_enable) mem[mem_addr[7:2]] <= mem_write_data;
    end
  end

  // ---------------- scoring ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One full access from an IDLE cycle; leaves the bench in the next IDLE cycle
  task automatic do_access(input int core, input logic [31:0] a, input logic w,
                           input logic [31:0] wd, input logic [31:0] exp_rd,
                           input string tag);
    if (core == 0) begin
      req0 = 1'b1; addr0 = a; we0 = w; wdata0 = wd;
    end else begin
      req1 = 1'b1; addr1 = a; we1 = w; wdata1 = wd;
    end
    check({tag, "_idle_we"}, 64'(mem_write_enable), 64'd0);
    tick();  // ISSUE
    check({tag, "_issue_we"},    64'(mem_write_enable), 64'(w));
    check({tag, "_issue_addr"},  64'(mem_addr), 64'(a));
    check({tag, "_issue_wdata"}, 64'(mem_write_data), 64'(wd));
    tick();  // CAPTURE
    check({tag, "_capture_we"},  64'(mem_write_enable), 64'd0);
    check({tag, "_capture_ack"}, 64'({ack1, ack0}), 64'd0);
    tick();  // DONE
    check({tag, "_done_we"},  64'(mem_write_enable), 64'd0);
    check({tag, "_done_ack"}, 64'({ack1, ack0}), (core == 0) ? 64'd1 : 64'd2);
    check({tag, "_rdata"}, 64'((core == 0) ? rdata0 : rdata1), 64'(exp_rd));
    if (core == 0) req0 = 1'b0; else req1 = 1'b0;
    tick();  // IDLE
    check({tag, "_after_ack"},   64'({ack1, ack0}), 64'd0);
    check({tag, "_after_state"}, 64'(dbg_state), 64'(IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic exp_a0, exp_a1;
    req0 = 0; req1 = 0; addr0 = '0; addr1 = '0;
    we0 = 0; we1 = 0; wdata0 = '0; wdata1 = '0;

    // Reset
    tick(); tick();
    mem_init = 1'b0;
    reset    = 1'b0;
    check("rst_state",  64'(dbg_state), 64'(IDLE));
    check("rst_ack",    64'({ack1, ack0}), 64'd0);
    check("rst_rdata0", 64'(rdata0), 64'd0);
    check("rst_rdata1", 64'(rdata1), 64'd0);
    check("rst_maddr",  64'(mem_addr), 64'd0);
    check("rst_mwdata", 64'(mem_write_data), 64'd0);
    check("rst_mwe",    64'(mem_write_enable), 64'd0);
    tick();

    // Simultaneous loads: core 0 wins first tie after reset
    req0 = 1; addr0 = 32'h0; we0 = 0;
    req1 = 1; addr1 = 32'h4; we1 = 0;
    tick(); tick();
    check("sim_c2_ack", 64'({ack1, ack0}), 64'd0);
    tick();
    check("sim_ack0",   64'({ack1, ack0}), 64'd1);
    check("sim_rdata0", 64'(rdata0), 64'h11);
    req0 = 0;
    for (int k = 4; k < 7; k++) begin
      tick();
      check("sim_wait_ack1", 64'({ack1, ack0}), 64'd0);
    end
    tick();
    check("sim_ack1",       64'({ack1, ack0}), 64'd2);
    check("sim_rdata1",     64'(rdata1), 64'h22);
    check("sim_rdata0_hold", 64'(rdata0), 64'h11);
    req1 = 0;
    tick();
    check("sim_idle", 64'(dbg_state), 64'(IDLE));

    // Core 0 requesting continuously with core 1 waiting
    req0 = 1; addr0 = 32'h0; we0 = 0;
    req1 = 1; addr1 = 32'h4; we1 = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_a0 = 1'b0;
      exp_a1 = 1'b0;
      if (k % 4 == 3) begin
`ifdef ARB_ROUND_ROBIN_EN
        if (((k / 4) % 2) == 0) exp_a0 = 1'b1; else exp_a1 = 1'b1;
`else
        exp_a0 = 1'b1;
`endif
      end
      check("cont_ack0", 64'(ack0), 64'(exp_a0));
      check("cont_ack1", 64'(ack1), 64'(exp_a1));
      if (exp_a0) check("cont_rdata0", 64'(rdata0), 64'h11);
      if (exp_a1) check("cont_rdata1", 64'(rdata1), 64'h22);
    end
    req0 = 0; req1 = 0;
    tick();
    check("cont_idle", 64'(dbg_state), 64'(IDLE));

    // Store then load from core 0
    do_access(0, 32'h40, 1'b1, 32'hDEADBEEF, 32'h0, "st0");
    do_access(0, 32'h40, 1'b0, 32'h0, 32'hDEADBEEF, "ld0");

    // Store returns the old contents; a following load sees the new value
    do_access(1, 32'h80, 1'b1, 32'h5, 32'h3, "st1");
    do_access(1, 32'h80, 1'b0, 32'h0, 32'h5, "ld1");

    // Reset during ISSUE of a store
    req0 = 1; addr0 = 32'h10; we0 = 1; wdata0 = 32'h77;
    tick();
    check("rm_state_issue", 64'(dbg_state), 64'(ISSUE));
    check("rm_we_before",   64'(mem_write_enable), 64'd1);
    reset = 1'b1;
    req0  = 1'b0;
    #1;
    check("rm_we_in_reset", 64'(mem_write_enable), 64'd0);
    tick();
    reset = 1'b0;
    check("rm_state",  64'(dbg_state), 64'(IDLE));
    check("rm_ack",    64'({ack1, ack0}), 64'd0);
    check("rm_rdata0", 64'(rdata0), 64'd0);
    check("rm_rdata1", 64'(rdata1), 64'd0);
    check("rm_maddr",  64'(mem_addr), 64'd0);
    check("rm_mwdata", 64'(mem_write_data), 64'd0);
    check("rm_mwe",    64'(mem_write_enable), 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rm_no_ack", 64'({ack1, ack0}), 64'd0);
    end
    check("rm_mem_untouched", 64'(mem[4]), 64'd0);
    do_access(0, 32'h10, 1'b0, 32'h0, 32'h0, "rm_ld");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shared_mem_arbiter.md
# shared_mem_arbiter

Two-port request arbiter sitting between the two CPU cores and the single-port `SharedMemory` responder. Accepts independent load/store requests from core 0 and core 1 and serialises them onto the memory's addr/write_enable/write_data port. Captures the memory's one-cycle-latency registered read_data and returns it to the granted core with a single-cycle acknowledge.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width passed through to memory.
- `DATA_W`, 32, data word width.

Ports:
- `clock` input 1: single clock. All logic is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `req0` / `req1` input 1: core N request; held high until that core's ack.
- `addr0` / `addr1` input ADDR_W: core N byte address; must be stable while req is high.
- `we0` / `we1` input 1: core N request type, 1 = store, 0 = load.
- `wdata0` / `wdata1` input DATA_W: core N store data.
- `ack0` / `ack1` output 1: one-cycle pulse; core N's access is complete.
- `rdata0` / `rdata1` output DATA_W: memory word at the request address, valid while ack is high.
- `mem_addr` output ADDR_W: to memory addr.
- `mem_write_enable` output 1: to memory write_enable.
- `mem_write_data` output DATA_W: to memory write_data.
- `mem_read_data` input DATA_W: from memory read_data, registered inside the memory with 1-cycle latency.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, DONE.
- **IDLE**:
  - If any req is high at the edge, choose a winner and latch its addr/we/wdata plus the grant id, then go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE**:
  - mem_addr and mem_write_data drive the latched values.
  - mem_write_enable = latched we AND NOT reset.
  - Always go to CAPTURE.
- **CAPTURE**:
  - mem_read_data holds the word read at the ISSUE edge. For a store this is the pre-write contents, because the memory reads before it writes.
  - At the edge, register mem_read_data into the winner's rdata and set the winner's ack.
  - Go to DONE.
- **DONE**:
  - Winner's ack = 1 for this cycle only.
  - Go to IDLE.
- Outside ISSUE:
  - mem_write_enable = 0.
  - mem_addr and mem_write_data hold their last values.
- Loser rdata: keeps its previous value; its ack stays 0.
- Simultaneous requests: the winner is picked by the policy under Configuration. The loser keeps req high and is served on the next IDLE.
- Requester rule: a core samples ack, then drops req in the following cycle. A req still high in the cycle after ack is treated as a new request.
- Addresses are passed through unmodified. Low bits [1:0] are ignored by the memory, and no alignment check is made.
- **Reset** (any state, including mid-access):
  - State -> IDLE.
  - ack0 = ack1 = 0; rdata0 = rdata1 = 0.
  - mem_addr = 0, mem_write_data = 0, mem_write_enable = 0.
  - Grant-history register -> core 1, so core 0 wins the first tie.
  - An access interrupted by reset is dropped; its core must re-request.
  - No memory write occurs in any cycle in which reset is high.

## Timing
- Request visible in IDLE at cycle 0 -> ISSUE in cycle 1 -> CAPTURE in cycle 2 -> ack and rdata in cycle 3.
- Fixed latency: 3 cycles from the sampling edge to ack.
- Throughput: one access per 4 cycles. Back-to-back from alternating cores: the next grant is sampled in the IDLE cycle following DONE.
- ack0 and ack1 are never high together.
- All outputs are registered except mem_write_enable, which is gated combinationally by reset.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - On a tie, grant the core not granted most recently.
  - The grant-history register updates on every grant.
- Undefined:
  - Fixed priority; core 0 always wins a tie.
  - The grant-history register is removed.
  - Core 1 can starve if core 0 re-requests continuously.

## Structure
- `shared_mem_pkg` holds:
  - The state enum (IDLE, ISSUE, CAPTURE, DONE).
  - Core-id constants CORE0 = 0 and CORE1 = 1.
  - N_CORES = 2.
- Sub-module `rr_arbiter2`:
  - Inputs: req[1:0], last grant.
  - Output: one-hot grant[1:0].
  - Contains the round-robin/fixed-priority selection under `ARB_ROUND_ROBIN_EN`.

## Test plan
- **Store then load.** Core 0 stores 0xDEADBEEF at 0x40, then loads 0x40.
  - Store: mem_write_enable high exactly 1 cycle with mem_addr = 0x40; ack0 3 cycles after the request.
  - Load: rdata0 = 0xDEADBEEF with ack0.
- **Simultaneous load requests.** req0 and req1 both rise in the same cycle, loading 0x0 and 0x4 (preloaded with 0x11 and 0x22).
  - ack0 arrives with rdata0 = 0x11.
  - ack1 arrives 4 cycles later with rdata1 = 0x22.
- **Continuous core 0 with core 1 waiting.** req0 re-asserted every cycle after its ack; req1 held high.
  - With `ARB_ROUND_ROBIN_EN`: grants alternate 0, 1, 0, 1.
  - Without it: ack1 never occurs within 20 cycles.
- **Store during the same access reads old data.** Core 1 stores 0x5 to 0x80, which holds 0x3.
  - rdata1 = 0x3 with ack1.
  - A following load of 0x80 returns 0x5.
- **Reset mid-access.** Assert reset during ISSUE of a store of 0x77 to 0x10.
  - mem_write_enable stays 0.
  - No ack.
  - All outputs are 0 on the cycle after reset.
  - A load of 0x10 then returns 0x0.
